minmax_scan_ctrl: RTL and testbench

Sequential controller that streams a block of signed 16-bit operands and reports the running minimum and maximum. It uses one shared subtract-based comparator, time-multiplexed between the min and max decisions. It sits between the MCU data bus and the ALU compare datapath, replacing two parallel less/greater comparators with a single comparator sequenced by an FSM. Typical uses are block statistics and clamp-range discovery.

---
 rtl/minmax_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_minmax_scan_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/minmax_scan_ctrl.sv
// Running min/max scanner over a block of signed 16-bit samples. A single
// subtract-based comparator is shared between the min and max decisions.
module minmax_scan_ctrl #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic [15:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [15:0]        min_out,
  output logic [15:0]        max_out,
  output logic               busy,
  output logic               done
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DIFF_W = DATA_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCEPT  = 3'd1,
    CMP_MIN = 3'd2,
    CMP_MAX = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state;
  logic [COUNT_W-1:0]  count;
  logic                first;
  logic [DATA_W-1:0]   sample;

  logic                cmp_en;
  logic [DATA_W-1:0]   cmp_a;
  logic [DATA_W-1:0]   cmp_b;
  logic [DIFF_W-1:0]   cmp_diff;
  logic                cmp_lt;
  logic                cmp_gt;

  // Shared comparator: sign-extended 17-bit subtract gives an overflow-free signed compare
  always_comb begin
    cmp_en   = (state == CMP_MIN) || (state == CMP_MAX);
    cmp_a    = '0;
    cmp_b    = '0;
    if (cmp_en) begin
      cmp_a = sample;
      cmp_b = (state == CMP_MIN) ? min_out : max_out;
    end
    cmp_diff = {cmp_a[DATA_W-1], cmp_a} - {cmp_b[DATA_W-1], cmp_b};
    cmp_lt   = cmp_diff[DIFF_W-1];
    cmp_gt   = !cmp_diff[DIFF_W-1] && (cmp_diff != '0);
  end

  // Scan sequencer with registered status outputs, loaded alongside the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      first    <= 1'b0;
      sample   <= '0;
      min_out  <= '0;
      max_out  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              count    <= len;
              first    <= 1'b1;
              in_ready <= 1'b1;
              state    <= ACCEPT;
            end else begin
              min_out <= '0;
              max_out <= '0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            sample   <= in_data;
            count    <= count - COUNT_W'(1);
            in_ready <= 1'b0;
            if (first) begin
              min_out <= in_data;
              max_out <= in_data;
              first   <= 1'b0;
              if (count == COUNT_W'(1)) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                in_ready <= 1'b1;
              end
            end else begin
              state <= CMP_MIN;
            end
          end
        end
        CMP_MIN: begin
          if (cmp_lt) min_out <= sample;
          state <= CMP_MAX;
        end
        CMP_MAX: begin
          if (cmp_gt) max_out <= sample;
          if (count == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= ACCEPT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Self-checking bench for minmax_scan_ctrl: vector table plus reset sequences.
module tb_minmax_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] min_out;
  logic [15:0] max_out;
  logic        busy;
  logic        done;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  minmax_scan_ctrl #(.COUNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .min_out(min_out), .max_out(max_out), .busy(busy), .done(done)
  );

  typedef struct {
    logic [7:0]       len;
    logic [3:0][15:0] s;
    int               stall;
    int               start_cyc;
    logic [15:0]      emin;
    logic [15:0]      emax;
    int               edone;
    logic [31:0]      emask;
  } vec_t;

  typedef struct {
    logic [15:0] emin;
    logic [15:0] emax;
    int          edone;
    logic [31:0] emask;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  function automatic vec_t mk(input logic [7:0] l, input logic [15:0] s0, s1, s2, s3,
                              input int st, input int sc, input logic [15:0] mn, mx,
                              input int dc, input logic [31:0] mask);
    vec_t v;
    v.len = l; v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
    v.stall = st; v.start_cyc = sc; v.emin = mn; v.emax = mx;
    v.edone = dc; v.emask = mask;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one scan from the vector, pushing the expectation and popping it at done
  task automatic run_vec(input vec_t v, input string tag);
    exp_t        e;
    int          idx, gap, done_cyc;
    logic [31:0] mask;
    e.emin = v.emin; e.emax = v.emax; e.edone = v.edone; e.emask = v.emask;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; len = v.len; in_valid = 1'b0;
    @(posedge clk);
    idx = 0; gap = 0; mask = '0; done_cyc = 0;
    for (int cyc = 1; cyc <= 100 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      start = (v.start_cyc == cyc);
      len   = 8'd9;
      if (in_ready && cyc < 32) mask[cyc] = 1'b1;
      if (done) begin
        done_cyc = cyc;
        check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        in_valid = 1'b0;
      end else if (in_ready && idx < int'(v.len)) begin
        if (gap < v.stall) begin
          in_valid = 1'b0;
          gap++;
        end else begin
          in_valid = 1'b1;
          in_data  = v.s[idx];
          idx++;
          gap = 0;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    if (done_cyc == 0) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout: got no done expected done in cycle %0d", tag, e.edone);
    end else begin
      check({tag, "_done_cycle"}, 32'(done_cyc), 32'(e.edone));
      check({tag, "_min"}, 32'(min_out), 32'(e.emin));
      check({tag, "_max"}, 32'(max_out), 32'(e.emax));
      check({tag, "_ready_mask"}, mask, e.emask);
    end
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0] = mk(8'd4, 16'h0005, 16'hFFFD, 16'h0064, 16'h0007, 0, 0, 16'hFFFD, 16'h0064, 11, 32'h0000_0126);
    vecs[1] = mk(8'd3, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 0, 0, 16'h8000, 16'h7FFF, 8, 32'h0000_0026);
    vecs[2] = mk(8'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 32'h0);
    vecs[3] = mk(8'd1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h1234, 16'h1234, 2, 32'h0000_0002);
    vecs[4] = mk(8'd3, 16'h0010, 16'h0010, 16'h0010, 16'h0000, 0, 0, 16'h0010, 16'h0010, 8, 32'h0000_0026);
    vecs[5] = mk(8'd2, 16'h0020, 16'hFF80, 16'h0000, 16'h0000, 3, 6, 16'hFF80, 16'h0020, 11, 32'h0000_01FE);
    vecs[6] = mk(8'd2, 16'h0003, 16'h0001, 16'h0000, 16'h0000, 0, 0, 16'h0001, 16'h0003, 5, 32'h0000_0006);

    // Reset with arbitrary inputs, including a start request
    rst_n = 1'b0; start = 1'b1; len = 8'd5; in_data = 16'hABCD; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_min", 32'(min_out), 32'h0);
    check("rst_max", 32'(max_out), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during CMP_MIN of the second sample aborts the scan
    @(negedge clk);
    start = 1'b1; len = 8'd3; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 16'h0001;
    @(negedge clk);
    in_data = 16'h0002;
    @(negedge clk);
    check("midrst_state_cmp", 32'(in_ready), 32'h0);
    rst_n = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midrst_no_done%0d", k), 32'(done), 32'h0);
      check($sformatf("midrst_busy%0d", k), 32'(busy), 32'h0);
    end
    check("midrst_min", 32'(min_out), 32'h0);
    check("midrst_max", 32'(max_out), 32'h0);
    rst_n = 1'b1;
    run_vec(vecs[6], "vec6");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
